rom_image_loader: RTL

- Writer side of the cartridge ROM interface. It accepts a byte stream over a valid/ready handshake and writes it sequentially into the 4 x 4096-byte cartridge image store: shadow RAM banks that stand in for rom_2600_0..3 wherever the image is loaded at run time instead of fixed in macros.
- Produces one registered write per accepted byte, with auto-incrementing address and bank, and signals completion.

---
 rtl/rom_image_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rom_image_loader.sv
// Streams bytes from a valid/ready source into the 4 x 4096-byte cartridge image store,
// one registered write per accepted byte. Define ROM_LOADER_CHECKSUM_EN to add a running 16-bit byte sum.
module rom_image_loader #(
    parameter int ADDR_W = 12,
    parameter int BANK_W = 2,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BANK_W-1:0] start_bank,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
`ifdef ROM_LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    localparam int PTR_W = BANK_W + ADDR_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << PTR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg;
    logic [LEN_W-1:0]   rem_reg;
    logic [LEN_W-1:0]   len_clamped;
    logic               start_accept;
    logic               transfer;
    logic               wr_en_reg;
    logic [BANK_W-1:0]  wr_bank_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [7:0]         wr_data_reg;

    assign len_clamped  = (length > MAX_LEN) ? MAX_LEN : length;
    assign start_accept = (state_reg == IDLE) && start;
    assign transfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (transfer && rem_reg == LEN_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == LOAD);
        busy     = (state_reg != IDLE);
        done     = (state_reg == DONE);
    end

    // The {bank, addr} pointer is one counter, so address wrap carries into the bank
    // and the top bank wraps back to bank 0 for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg     <= '0;
            rem_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_bank_reg <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= transfer;
            if (start_accept) begin
                ptr_reg <= {start_bank, start_addr};
                rem_reg <= len_clamped;
            end
            if (transfer) begin
                wr_bank_reg <= ptr_reg[PTR_W-1:ADDR_W];
                wr_addr_reg <= ptr_reg[ADDR_W-1:0];
                wr_data_reg <= in_data;
                ptr_reg     <= ptr_reg + PTR_W'(1);
                rem_reg     <= rem_reg - LEN_W'(1);
            end
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_bank = wr_bank_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum_reg;

    // Accumulates on the transfer so the new sum appears alongside its write strobe.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            checksum_reg <= '0;
        end else if (transfer) begin
            checksum_reg <= checksum_reg + {8'd0, in_data};
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule
